// File: rtl/apb_wait_slave.sv
// ---------------------------------------------------------------------------
// apb_wait_slave
//   APB slave with a byte register file. Every transfer takes a fixed number of
//   wait states before it completes. Address 0xFF holds a read-only ID byte.
//   Any other address at or above DEPTH returns an error response.
//
// Parameters
//   WAIT  : wait states (PREADY low access cycles) per transfer, 0..7
//   DEPTH : number of byte registers, mapped at 0x00..DEPTH-1
//   ID    : identification byte returned on reads of 0xFF
//
// Ports
//   PCLK    in   sole clock, rising edge
//   PRESET  in   synchronous active-high reset
//   PSEL    in   slave select
//   PENABLE in   access-phase strobe
//   PWRITE  in   1 = write, 0 = read
//   PADDR   in   [7:0] byte address
//   PWDATA  in   [7:0] write data
//   PRDATA  out  [7:0] read data, non-zero only in a read PREADY cycle
//   PREADY  out  transfer completion, one cycle per transfer
//   PSLVERR out  error response, qualified by PREADY
// ---------------------------------------------------------------------------
module apb_wait_slave #(
  parameter int         WAIT  = 2,
  parameter int         DEPTH = 32,
  parameter logic [7:0] ID    = 8'hA5
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR
);

  localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] WAIT_CNT  = 3'(WAIT);
  localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);
  localparam logic [7:0] ID_ADDR   = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACCESS = 2'd3
  } state_t;

  state_t       state_r;
  state_t       phase_s;
  logic [2:0]   cnt_r;
  logic [7:0]   addr_r;
  logic [7:0]   wdata_r;
  logic         write_r;
  logic [7:0]   mem_r [DEPTH];
  logic [7:0]   prdata_r;
  logic         pready_r;
  logic         pslverr_r;

  logic [7:0]   addr_s;
  logic [7:0]   wdata_s;
  logic         write_s;
  logic [AW-1:0] idx_s;
  logic         addr_valid_s;
  logic         addr_id_s;
  logic         err_s;
  logic [7:0]   rdata_s;
  logic         finish_s;

  // The setup cycle can only be observed while it is on the bus. The stored
  // state is therefore promoted to SETUP in that same cycle. This lets a
  // zero-wait transfer raise PREADY in the very next cycle.
  always_comb begin
    phase_s = state_r;
    if (((state_r == ST_IDLE) || (state_r == ST_ACCESS)) && PSEL && !PENABLE) begin
      phase_s = ST_SETUP;
    end else begin
      phase_s = state_r;
    end
  end

  // Transfer operands: taken live from the bus in the setup cycle and from
  // the latched copies afterwards. Later bus changes are ignored.
  always_comb begin
    addr_s       = (phase_s == ST_SETUP) ? PADDR  : addr_r;
    wdata_s      = (phase_s == ST_SETUP) ? PWDATA : wdata_r;
    write_s      = (phase_s == ST_SETUP) ? PWRITE : write_r;
    idx_s        = addr_s[AW-1:0];
    addr_valid_s = ({1'b0, addr_s} < DEPTH_LIM);
    addr_id_s    = (addr_s == ID_ADDR);
    // The ID byte may be read but not written. Any other address is an
    // error when it lies beyond the register file.
    err_s        = addr_id_s ? write_s : !addr_valid_s;
    rdata_s      = addr_id_s ? ID : (addr_valid_s ? mem_r[idx_s] : 8'h00);
    // This cycle is the last one before the access (PREADY) cycle.
    finish_s     = ((phase_s == ST_SETUP) && (WAIT_CNT == 3'd0)) ||
                   ((phase_s == ST_WAIT) && PSEL && PENABLE && (cnt_r <= 3'd1));
  end

  // Transfer FSM, register file and registered bus responses.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 3'd0;
      addr_r    <= 8'h00;
      wdata_r   <= 8'h00;
      write_r   <= 1'b0;
      prdata_r  <= 8'h00;
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else begin
      // Responses are prepared on the edge that enters ACCESS, so they are
      // visible exactly in the PREADY cycle and return to zero afterwards.
      pready_r  <= finish_s;
      pslverr_r <= finish_s && err_s;
      prdata_r  <= (finish_s && !write_s && !err_s) ? rdata_s : 8'h00;
      // The write lands on the same edge, so an aborted transfer never
      // reaches this point.
      if (finish_s && write_s && !err_s) begin
        mem_r[idx_s] <= wdata_s;
      end

      case (phase_s)
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end
        ST_SETUP: begin
          addr_r  <= PADDR;
          wdata_r <= PWDATA;
          write_r <= PWRITE;
          cnt_r   <= WAIT_CNT;
          state_r <= (WAIT_CNT == 3'd0) ? ST_ACCESS : ST_WAIT;
        end
        ST_WAIT: begin
          if (PSEL && PENABLE) begin
            cnt_r   <= cnt_r - 3'd1;
            state_r <= (cnt_r <= 3'd1) ? ST_ACCESS : ST_WAIT;
          end else begin
            // If the master drops out mid-transfer, the transfer is abandoned.
            cnt_r   <= 3'd0;
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign PRDATA  = prdata_r;
  assign PREADY  = pready_r;
  assign PSLVERR = pslverr_r;

endmodule

// File: tb/tb_apb_wait_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_wait_slave
//   Directed bench for apb_wait_slave. It uses three instances that share the
//   bus lines, each with its own PSEL and PRESET:
//     u_w2 : WAIT=2    u_w0 : WAIT=0    u_w3 : WAIT=3
//   All expected values are hand-computed constants or come from a small
//   shadow array of the WAIT=2 register file.
// ---------------------------------------------------------------------------
module tb_apb_wait_slave;

  logic       clk;
  logic [2:0] preset_v;
  logic [2:0] psel_v;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata_v [3];
  logic [2:0] pready_v;
  logic [2:0] pslverr_v;

  int         n_checks;
  int         n_fail;
  logic [7:0] model [32];

  apb_wait_slave #(.WAIT(2), .DEPTH(32), .ID(8'hA5)) u_w2 (
    .PCLK(clk), .PRESET(preset_v[0]), .PSEL(psel_v[0]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata_v[0]), .PREADY(pready_v[0]), .PSLVERR(pslverr_v[0]));

  apb_wait_slave #(.WAIT(0), .DEPTH(32), .ID(8'hA5)) u_w0 (
    .PCLK(clk), .PRESET(preset_v[1]), .PSEL(psel_v[1]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata_v[1]), .PREADY(pready_v[1]), .PSLVERR(pslverr_v[1]));

  apb_wait_slave #(.WAIT(3), .DEPTH(32), .ID(8'hA5)) u_w3 (
    .PCLK(clk), .PRESET(preset_v[2]), .PSEL(psel_v[2]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata_v[2]), .PREADY(pready_v[2]), .PSLVERR(pslverr_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check that instance k shows no response in the current cycle.
  task automatic chk_quiet(input int k, input string tag);
    chk({tag, "_rdy"},  {7'd0, pready_v[k]},  8'h00);
    chk({tag, "_err"},  {7'd0, pslverr_v[k]}, 8'h00);
    chk({tag, "_data"}, prdata_v[k],          8'h00);
  endtask

  // One complete transfer on instance k with w wait states. In the first
  // access cycle the address and data lines are scrambled; the slave must
  // keep using the values from the setup cycle.
  task automatic xfer(input int k, input int w, input logic wr, input logic [7:0] addr,
                      input logic [7:0] wd, input logic [7:0] exp_rd, input logic exp_err,
                      input string tag);
    @(posedge clk); #1;
    psel_v    = 3'b000;
    psel_v[k] = 1'b1;
    penable   = 1'b0;
    pwrite    = wr;
    paddr     = addr;
    pwdata    = wd;
    @(negedge clk);
    chk({tag, "_setup_rdy"}, {7'd0, pready_v[k]}, 8'h00);
    for (int c = 1; c <= w + 1; c++) begin
      @(posedge clk); #1;
      penable = 1'b1;
      if (c == 1) begin
        paddr  = ~addr;
        pwdata = ~wd;
      end
      @(negedge clk);
      if (c <= w) begin
        chk($sformatf("%s_wait%0d_rdy", tag, c), {7'd0, pready_v[k]}, 8'h00);
        chk($sformatf("%s_wait%0d_data", tag, c), prdata_v[k], 8'h00);
      end else begin
        chk({tag, "_rdy"},  {7'd0, pready_v[k]},  8'h01);
        chk({tag, "_err"},  {7'd0, pslverr_v[k]}, {7'd0, exp_err});
        chk({tag, "_data"}, prdata_v[k],          exp_rd);
      end
    end
  endtask

  task automatic bus_idle(input int k, input string tag);
    @(posedge clk); #1;
    psel_v  = 3'b000;
    penable = 1'b0;
    @(negedge clk);
    chk_quiet(k, tag);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    preset_v = 3'b111;
    psel_v   = 3'b000;
    penable  = 1'b0;
    pwrite   = 1'b0;
    paddr    = 8'h00;
    pwdata   = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1 preset_v = 3'b000;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk_quiet(k, $sformatf("reset%0d", k));

    // A lone PENABLE without a setup cycle is ignored
    @(posedge clk); #1;
    psel_v = 3'b111; penable = 1'b1; pwrite = 1'b1; paddr = 8'h01; pwdata = 8'hEE;
    repeat (4) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) chk_quiet(k, $sformatf("noset%0d", k));
      @(posedge clk); #1;
    end
    psel_v = 3'b000; penable = 1'b0;

    // WAIT=2: write 0x3C to 0x05, then read it back
    xfer(0, 2, 1'b1, 8'h05, 8'h3C, 8'h00, 1'b0, "w2_wr05");
    model[5] = 8'h3C;
    bus_idle(0, "w2_idle1");
    xfer(0, 2, 1'b0, 8'h05, 8'h00, 8'h3C, 1'b0, "w2_rd05");
    bus_idle(0, "w2_idle2");
    xfer(0, 2, 1'b0, 8'h01, 8'h00, 8'h00, 1'b0, "w2_rd01");
    bus_idle(0, "w2_idle_noset");

    // WAIT=0: back-to-back writes then back-to-back reads
    xfer(1, 0, 1'b1, 8'h00, 8'h11, 8'h00, 1'b0, "w0_wr00");
    xfer(1, 0, 1'b1, 8'h1F, 8'h22, 8'h00, 1'b0, "w0_wr1f");
    xfer(1, 0, 1'b0, 8'h00, 8'h00, 8'h11, 1'b0, "w0_rd00");
    xfer(1, 0, 1'b0, 8'h1F, 8'h00, 8'h22, 1'b0, "w0_rd1f");
    bus_idle(1, "w0_idle1");

    // ID register
    xfer(1, 0, 1'b0, 8'hFF, 8'h00, 8'hA5, 1'b0, "w0_rdid");
    xfer(1, 0, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, "w0_wrid");
    xfer(1, 0, 1'b0, 8'hFF, 8'h00, 8'hA5, 1'b0, "w0_rdid2");
    bus_idle(1, "w0_idle2");

    // Out-of-range accesses on the WAIT=2 instance, then full readback
    xfer(0, 2, 1'b0, 8'h20, 8'h00, 8'h00, 1'b1, "w2_rd20");
    xfer(0, 2, 1'b1, 8'h80, 8'h55, 8'h00, 1'b1, "w2_wr80");
    bus_idle(0, "w2_idle3");
    for (int a = 0; a < 32; a++) begin
      xfer(0, 2, 1'b0, 8'(a), 8'h00, model[a], 1'b0, $sformatf("w2_rb%0d", a));
    end
    bus_idle(0, "w2_idle4");

    // WAIT=3: write 0x12 to 0x04, then reset during a wait cycle of a
    // write of 0x77 to 0x04
    xfer(2, 3, 1'b1, 8'h04, 8'h12, 8'h00, 1'b0, "w3_wr04");
    bus_idle(2, "w3_idle1");
    @(posedge clk); #1;
    psel_v = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 8'h77;
    @(negedge clk); chk("w3_abort_setup_rdy", {7'd0, pready_v[2]}, 8'h00);
    @(posedge clk); #1; penable = 1'b1;
    @(negedge clk); chk("w3_abort_wait1_rdy", {7'd0, pready_v[2]}, 8'h00);
    @(posedge clk); #1; preset_v[2] = 1'b1;
    @(negedge clk); chk("w3_abort_wait2_rdy", {7'd0, pready_v[2]}, 8'h00);
    @(posedge clk); #1; preset_v[2] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_quiet(2, $sformatf("w3_after_rst%0d", c));
      @(posedge clk); #1;
    end
    psel_v = 3'b000; penable = 1'b0;
    xfer(2, 3, 1'b0, 8'h04, 8'h00, 8'h00, 1'b0, "w3_rd04");
    bus_idle(2, "w3_idle2");

    // WAIT=2: write 0x4B to 0x02, then drop PSEL mid-wait on a write of 0x99
    xfer(0, 2, 1'b1, 8'h02, 8'h4B, 8'h00, 1'b0, "w2_wr02");
    bus_idle(0, "w2_idle5");
    @(posedge clk); #1;
    psel_v = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 8'h02; pwdata = 8'h99;
    @(negedge clk); chk("w2_drop_setup_rdy", {7'd0, pready_v[0]}, 8'h00);
    @(posedge clk); #1; penable = 1'b1;
    @(negedge clk); chk("w2_drop_wait1_rdy", {7'd0, pready_v[0]}, 8'h00);
    @(posedge clk); #1; psel_v = 3'b000;
    @(negedge clk); chk("w2_drop_wait2_rdy", {7'd0, pready_v[0]}, 8'h00);
    @(posedge clk); #1;
    @(negedge clk); chk_quiet(0, "w2_drop_after");
    // Reselecting with PENABLE still high is not a new setup
    @(posedge clk); #1; psel_v = 3'b001;
    @(negedge clk); chk_quiet(0, "w2_resel1");
    @(posedge clk); #1;
    @(negedge clk); chk_quiet(0, "w2_resel2");
    @(posedge clk); #1; psel_v = 3'b000; penable = 1'b0;
    xfer(0, 2, 1'b0, 8'h02, 8'h00, 8'h4B, 1'b0, "w2_rd02");
    bus_idle(0, "w2_idle6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_wait_slave.md
APB_WAIT_SLAVE -- requirements
Module: apb_wait_slave

Interface
REQ-001 SHALL have parameter WAIT, default 2: number of wait states (PREADY low access cycles) per transfer, range 0-7.
REQ-002 SHALL have parameter DEPTH, default 32: number of byte registers, at addresses 0x00..DEPTH-1.
REQ-003 SHALL have parameter ID, default 8'hA5: read-only identification byte at address 0xFF.
REQ-004 Ports:
- PCLK  in  1  sole clock; all state updates on rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase strobe.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  8  byte address.
- PWDATA  in  8  write data.
- PRDATA  out  8  read data.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response, qualified by PREADY.
REQ-005 SHALL use one clock domain; reset is synchronous and active-high.

Function
REQ-006 SHALL implement FSM IDLE, SETUP, WAIT, ACCESS.
REQ-007 IDLE -> SETUP when PSEL=1 and PENABLE=0; all other inputs leave the block in IDLE.
REQ-008 In SETUP, SHALL latch PADDR, PWRITE and PWDATA, and load the wait counter with WAIT.
REQ-009 SETUP -> WAIT if WAIT>0; SETUP -> ACCESS if WAIT=0.
REQ-010 In WAIT, the counter SHALL decrement once per cycle while PSEL=PENABLE=1; WAIT -> ACCESS when the counter reaches 0.
REQ-011 PREADY SHALL be 1 only in ACCESS, for exactly one cycle.
REQ-012 Latency: first access cycle = setup+1; PREADY=1 in access cycle WAIT+1; total transfer = WAIT+2 cycles.
REQ-013 Write with a valid address (< DEPTH) SHALL update the register in the PREADY cycle, never earlier.
REQ-014 Read with a valid address SHALL drive the register content on PRDATA in the PREADY cycle.
REQ-015 Read of 0xFF SHALL return ID with PSLVERR=0.
REQ-016 PRDATA SHALL be 8'h00 in every cycle other than a read PREADY cycle.
REQ-017 PSLVERR SHALL be 1 in the PREADY cycle when either condition holds:
- address >= DEPTH and address != 0xFF;
- write to 0xFF.
PSLVERR SHALL be 0 in all other cycles.
REQ-018 On error, the block SHALL leave all registers unchanged, and reads SHALL return 8'h00.
REQ-019 ACCESS -> SETUP when PSEL=1 and PENABLE=0 in the following cycle (back-to-back); otherwise ACCESS -> IDLE.
REQ-020 PSEL or PENABLE dropping during WAIT (protocol violation) SHALL abort:
- return to IDLE;
- no register write;
- PREADY stays 0.
REQ-021 PADDR/PWDATA changes after SETUP SHALL have no effect; the values latched in SETUP are used.
REQ-022 PENABLE=1 without a preceding setup cycle SHALL be ignored.

Reset
REQ-023 With PRESET=1 at a rising edge, the block SHALL:
- go to IDLE;
- clear the wait counter;
- clear all DEPTH registers to 8'h00;
- drive PREADY=0, PSLVERR=0, PRDATA=8'h00 from the next cycle.
REQ-024 Reset asserted mid-transfer SHALL abort it, discard the pending write, and produce no PREADY.

Verification
REQ-025 WAIT=2, write 0x3C to addr 0x05, then read 0x05 -> each PREADY is 1 in the 4th cycle of its transfer, PSLVERR=0, read PRDATA=0x3C.
REQ-026 WAIT=0, back-to-back writes 0x11@0x00 and 0x22@0x1F, then reads of both -> PREADY=1 in every access cycle, PRDATA 0x11 then 0x22.
REQ-027 Read 0x20 and write 0x55 to 0x80 -> PSLVERR=1 with PREADY; read PRDATA=0x00; readback of 0x00..0x1F unchanged.
REQ-028 Read 0xFF -> PRDATA=0xA5, PSLVERR=0; write 0x00 to 0xFF -> PSLVERR=1; reread of 0xFF still returns 0xA5.
REQ-029 WAIT=3, write 0x77 to 0x04 with PRESET pulsed during a wait cycle -> no PREADY; 0x04 reads 0x00 afterwards.
REQ-030 WAIT=2, PSEL dropped during a wait cycle on a write of 0x99 to 0x02 -> return to IDLE, no PREADY; 0x02 keeps its previous value.
